pool_trace_capture: RTL and testbench
=====================================

// Module: pool_trace_capture
// PURPOSE
//  On-chip, parametrised successor to the POOL dump monitor, synthesised so the data also exists on silicon.
//  Snoops NUM_CH valid/ready interfaces of POOL (CFGPOOL, GBPOOL, BF, BF_flg, ...).
//  Packs each fired beat, tagged with layer/patch/ftrgrp and a timestamp, into a trace FIFO.
//  The host drains the FIFO through a valid/ready port; per-segment marker records replace per-segment dump files.
// PARAMETERS
//  NUM_CH      4    monitored channels (1..8)
//  DATA_WIDTH  128  per-channel data width (narrower channels zero-extended at top level)
//  ADDR_WIDTH  16   per-channel address width
//  TAG_WIDTH   18   segment tag {layer[5:0],patch[5:0],ftrgrp[5:0]}
//  TS_WIDTH    16   timestamp width
//  DEPTH       64   trace FIFO entries (power of 2)
//  CH_W        $clog2(NUM_CH) (localparam, min 1); REC_W = 2+CH_W+TAG_WIDTH+TS_WIDTH+ADDR_WIDTH+DATA_WIDTH
// PORTS
//  clk          in   1                    single clock, all logic posedge
//  rst          in   1                    synchronous, active-high reset
//  cfg_en       in   1                    capture enable
//  cfg_mode     in   1                    0 = stop when full, 1 = wrap (overwrite oldest)
//  cfg_ch_mask  in   NUM_CH               1 = channel captured
//  seg_start    in   1                    pulse: new layer/patch/ftrgrp segment begins
//  seg_tag      in   TAG_WIDTH            tag sampled on seg_start
//  mon_val      in   NUM_CH               snooped valid, channel i = bit i
//  mon_rdy      in   NUM_CH               snooped ready
//  mon_data     in   NUM_CH*DATA_WIDTH    channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  mon_addr     in   NUM_CH*ADDR_WIDTH    channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//  rd_val       out  1                    record available
//  rd_rdy       in   1                    host accepts record
//  rd_data      out  REC_W                {type[1:0],ch,tag,ts,addr,data}; type 0 = beat, 1 = mark
//  trc_cnt      out  $clog2(DEPTH)+1      FIFO occupancy
//  trc_full     out  1                    occupancy == DEPTH
//  trc_drop     out  NUM_CH+1             sticky loss flags; bit NUM_CH = mark lost
// BEHAVIOUR
//  Reset: rd_val, trc_full, trc_drop = 0; trc_cnt = 0; FIFO pointers, timestamp and cur_tag = 0; rd_data = 0; FSM = IDLE.
//  FSM:
//   IDLE -> RUN when cfg_en = 1.
//   RUN  -> HALT when FIFO is full and cfg_mode = 0.
//   HALT -> RUN when a pop frees an entry.
//   RUN/HALT -> IDLE when cfg_en = 0. FIFO contents are kept and remain readable in every state.
//  Snoop: fire_i = mon_val[i] & mon_rdy[i] & cfg_ch_mask[i] & (FSM != IDLE).
//  Holding registers: one per channel. Fire at cycle t loads hold_i at t+1 with {addr, data, cur_tag, ts}.
//   Fire while hold_i is occupied and not written to the FIFO this cycle: the beat is dropped and trc_drop[i] is set.
//  seg_start in RUN/HALT: cur_tag <= seg_tag, ts <= 0, and the mark register is loaded with {type=1, tag}.
//   A second seg_start while a mark is pending overwrites the mark and sets trc_drop[NUM_CH].
//   Beats fired in the same cycle as seg_start carry the NEW tag and ts = 0.
//  Timestamp: free-running, increments every cycle outside IDLE, wraps modulo 2^TS_WIDTH.
//  Write arbiter (one FIFO write per cycle):
//   The pending mark has absolute priority.
//   Otherwise occupied holds are served round-robin, starting from the channel after the last one granted (reset pointer 0).
//   Granted entry is freed the same cycle.
//  Full, mode 0 (HALT): no writes. Holds keep their contents; further fires on those channels are dropped as above.
//  Full, mode 1: the write overwrites the oldest entry, rd pointer advances, trc_cnt stays at DEPTH.
//  Full with a same-cycle pop: normal write; no overwrite, no halt.
//  Read port: rd_val = (trc_cnt != 0); rd_data = FIFO head, held stable while rd_val & ~rd_rdy. Pop on rd_val & rd_rdy.
//  Latency: an uncontended fire at cycle t appears on rd_data at cycle t+2 if the FIFO was empty.
//  trc_drop clears only on rst or on the IDLE->RUN transition. The entire FIFO also clears on rst.
// TESTING
//  T1 Single beat: ch1 fire, addr=0x12, data=5, tag=0x01234 after seg_start
//     -> mark record, then beat {type0, ch1, tag 0x01234, addr 0x12, data 5}, beat rd_val at fire+2.
//  T2 Simultaneous fire on ch0..ch3, rd_rdy=1 -> order ch0, ch1, ch2, ch3; next simultaneous burst starts at ch0 (ptr after ch3).
//  T3 Mode 0: DEPTH+3 beats on ch0 with rd_rdy=0 -> trc_cnt=64, trc_full=1, FSM HALT, trc_drop[0]=1;
//     a single pop restores RUN and the held beat is written.
//  T4 Mode 1: DEPTH+5 beats with data=0..68, rd_rdy=0 -> trc_cnt=64, head data=5, no drop flags set.
//  T5 Two seg_start pulses back-to-back while ch2 beats saturate the arbiter -> only second tag marked, trc_drop[NUM_CH]=1.
//  T6 rst asserted mid-burst, then cfg_mask=0 with all mon_val=1 -> all outputs return to reset values; no records captured.

Source files
------------

// File: rtl/pool_trace_capture.sv
// Snoops POOL valid/ready channels and packs every fired beat, tagged with the current
// segment and a timestamp, into a trace FIFO that the host drains through a valid/ready port.
module pool_trace_capture #(
   parameter  int NUM_CH     = 4,
   parameter  int DATA_WIDTH = 128,
   parameter  int ADDR_WIDTH = 16,
   parameter  int TAG_WIDTH  = 18,
   parameter  int TS_WIDTH   = 16,
   parameter  int DEPTH      = 64,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int REC_W      = 2 + CH_W + TAG_WIDTH + TS_WIDTH + ADDR_WIDTH + DATA_WIDTH,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_en,
   input  logic                         cfg_mode,
   input  logic [NUM_CH-1:0]            cfg_ch_mask,
   input  logic                         seg_start,
   input  logic [TAG_WIDTH-1:0]         seg_tag,
   input  logic [NUM_CH-1:0]            mon_val,
   input  logic [NUM_CH-1:0]            mon_rdy,
   input  logic [NUM_CH*DATA_WIDTH-1:0] mon_data,
   input  logic [NUM_CH*ADDR_WIDTH-1:0] mon_addr,
   output logic                         rd_val,
   input  logic                         rd_rdy,
   output logic [REC_W-1:0]             rd_data,
   output logic [CNT_W-1:0]             trc_cnt,
   output logic                         trc_full,
   output logic [NUM_CH:0]              trc_drop
);

   localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BEAT_W   = TAG_WIDTH + TS_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam int MPAD_W   = TS_WIDTH + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t               state_r, state_nxt_s;
   logic [REC_W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
   logic [CNT_W-1:0]     cnt_r, cnt_nxt_s;
   logic                 full_r, rd_val_r;
   logic [NUM_CH:0]      drop_r;
   logic [NUM_CH-1:0]    hold_vld_r;
   logic [BEAT_W-1:0]    hold_r [NUM_CH];
   logic                 mark_vld_r;
   logic [TAG_WIDTH-1:0] mark_tag_r, cur_tag_r;
   logic [TS_WIDTH-1:0]  ts_r;
   logic [CH_W-1:0]      rr_r;

   logic                 active_s, seg_s, pop_s, wr_ok_s, wr_mark_s, wr_hold_s, wr_s, ovw_s;
   logic                 gnt_vld_s, mark_lost_s;
   logic [CH_W-1:0]      gnt_ch_s;
   logic [NUM_CH-1:0]    fire_s, freed_s, beat_lost_s;
   logic [TAG_WIDTH-1:0] beat_tag_s;
   logic [TS_WIDTH-1:0]  beat_ts_s;
   logic [REC_W-1:0]     wr_rec_s;

   assign active_s    = (state_r != ST_IDLE);
   assign seg_s       = seg_start & active_s;
   assign fire_s      = mon_val & mon_rdy & cfg_ch_mask & {NUM_CH{active_s}};
   assign pop_s       = rd_val_r & rd_rdy;
   // A full FIFO still accepts a write when a pop frees a slot or when wrapping is enabled.
   assign wr_ok_s     = ~full_r | pop_s | cfg_mode;
   assign wr_mark_s   = wr_ok_s & mark_vld_r;
   assign wr_hold_s   = wr_ok_s & ~mark_vld_r & gnt_vld_s;
   assign wr_s        = wr_mark_s | wr_hold_s;
   assign ovw_s       = wr_s & full_r & ~pop_s;
   assign beat_tag_s  = seg_s ? seg_tag : cur_tag_r;
   assign beat_ts_s   = seg_s ? {TS_WIDTH{1'b0}} : ts_r;
   assign mark_lost_s = seg_s & mark_vld_r & ~wr_mark_s;
   assign beat_lost_s = fire_s & hold_vld_r & ~freed_s;
   assign wr_rec_s    = wr_mark_s ? {2'd1, {CH_W{1'b0}}, mark_tag_r, {MPAD_W{1'b0}}}
                                  : {2'd0, gnt_ch_s, hold_r[gnt_ch_s]};
   assign cnt_nxt_s   = ovw_s ? cnt_r : (cnt_r + CNT_W'(wr_s) - CNT_W'(pop_s));

   assign rd_val   = rd_val_r;
   assign rd_data  = rd_val_r ? mem_r[rd_ptr_r] : {REC_W{1'b0}};
   assign trc_cnt  = cnt_r;
   assign trc_full = full_r;
   assign trc_drop = drop_r;

   // Round-robin search over occupied holds, beginning at rr_r.
   always_comb begin
      logic [CH_W-1:0] idx_v;
      logic            take_v;
      gnt_vld_s = 1'b0;
      gnt_ch_s  = {CH_W{1'b0}};
      idx_v     = {CH_W{1'b0}};
      take_v    = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx_v     = CH_W'((int'(rr_r) + k) % NUM_CH);
         take_v    = ~gnt_vld_s & hold_vld_r[idx_v];
         gnt_ch_s  = take_v ? idx_v : gnt_ch_s;
         gnt_vld_s = gnt_vld_s | take_v;
      end
   end

   // One-hot view of the hold being written this cycle.
   always_comb begin
      freed_s = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         freed_s[i] = wr_hold_s & (gnt_ch_s == CH_W'(i));
      end
   end

   // Capture FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cfg_en) state_nxt_s = ST_RUN;
            else        state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (!cfg_en)                          state_nxt_s = ST_IDLE;
            else if (full_r & ~cfg_mode & ~pop_s) state_nxt_s = ST_HALT;
            else                                  state_nxt_s = ST_RUN;
         end
         ST_HALT: begin
            if (!cfg_en)    state_nxt_s = ST_IDLE;
            else if (pop_s) state_nxt_s = ST_RUN;
            else            state_nxt_s = ST_HALT;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Capture FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_r <= ST_IDLE;
      else     state_r <= state_nxt_s;
   end

   // Trace storage; only entries between the pointers are meaningful, so no reset is needed.
   always_ff @(posedge clk) begin
      if (wr_s) mem_r[wr_ptr_r] <= wr_rec_s;
   end

   // FIFO pointers and occupancy status.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
         full_r   <= 1'b0;
         rd_val_r <= 1'b0;
      end else begin
         if (wr_s)          wr_ptr_r <= wr_ptr_r + 1'b1;
         if (pop_s | ovw_s) rd_ptr_r <= rd_ptr_r + 1'b1;
         cnt_r    <= cnt_nxt_s;
         full_r   <= (cnt_nxt_s == DEPTH_CNT);
         rd_val_r <= (cnt_nxt_s != {CNT_W{1'b0}});
      end
   end

   // Per-channel holding registers; a granted hold can take a new beat in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_vld_r <= {NUM_CH{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (fire_s[i] & ~beat_lost_s[i]) begin
               hold_vld_r[i] <= 1'b1;
               hold_r[i]     <= {beat_tag_s, beat_ts_s,
                                 mon_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                 mon_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end else if (freed_s[i]) begin
               hold_vld_r[i] <= 1'b0;
            end
         end
      end
   end

   // Segment marker, current tag and timestamp.
   always_ff @(posedge clk) begin
      if (rst) begin
         mark_vld_r <= 1'b0;
         mark_tag_r <= {TAG_WIDTH{1'b0}};
         cur_tag_r  <= {TAG_WIDTH{1'b0}};
         ts_r       <= {TS_WIDTH{1'b0}};
      end else if (seg_s) begin
         mark_vld_r <= 1'b1;
         mark_tag_r <= seg_tag;
         cur_tag_r  <= seg_tag;
         ts_r       <= {TS_WIDTH{1'b0}};
      end else begin
         if (wr_mark_s) mark_vld_r <= 1'b0;
         if (active_s)  ts_r       <= ts_r + 1'b1;
      end
   end

   // Round-robin pointer and sticky loss flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_r   <= {CH_W{1'b0}};
         drop_r <= {(NUM_CH+1){1'b0}};
      end else begin
         if (wr_hold_s) rr_r <= (gnt_ch_s == LAST_CH) ? {CH_W{1'b0}} : gnt_ch_s + 1'b1;
         if ((state_r == ST_IDLE) && cfg_en) drop_r <= {(NUM_CH+1){1'b0}};
         else                                drop_r <= drop_r | {mark_lost_s, beat_lost_s};
      end
   end

endmodule

// File: tb/tb_pool_trace_capture.sv
// Randomised and directed bench for pool_trace_capture: a reference model fills an expected
// record queue, and a negedge monitor compares every DUT output against it.
module tb_pool_trace_capture;

   localparam int NC    = 4;
   localparam int DW    = 128;
   localparam int AW    = 16;
   localparam int TW    = 18;
   localparam int SW    = 16;
   localparam int DEP   = 64;
   localparam int CHW   = 2;
   localparam int REC_W = 2 + CHW + TW + SW + AW + DW;
   localparam int CW    = 7;

   typedef logic [REC_W-1:0] rec_t;

   logic             clk = 1'b0;
   logic             rst, cfg_en, cfg_mode, seg_start, rd_rdy;
   logic [NC-1:0]    cfg_ch_mask, mon_val, mon_rdy;
   logic [TW-1:0]    seg_tag;
   logic [NC*DW-1:0] mon_data;
   logic [NC*AW-1:0] mon_addr;
   logic             rd_val, trc_full;
   rec_t             rd_data;
   logic [CW-1:0]    trc_cnt;
   logic [NC:0]      trc_drop;

   int n_cmp = 0;
   int n_err = 0;
   bit mon_on = 1'b0;

   pool_trace_capture dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_ch_mask(cfg_ch_mask),
      .seg_start(seg_start), .seg_tag(seg_tag), .mon_val(mon_val), .mon_rdy(mon_rdy),
      .mon_data(mon_data), .mon_addr(mon_addr), .rd_val(rd_val), .rd_rdy(rd_rdy),
      .rd_data(rd_data), .trc_cnt(trc_cnt), .trc_full(trc_full), .trc_drop(trc_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic rec_t mk_rec(input int typ, input int ch, input logic [TW-1:0] tag,
                                   input int ts, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      return {2'(typ), CHW'(ch), tag, SW'(ts), addr, data};
   endfunction

   // ---------------- reference model ----------------
   rec_t          exp_q[$];
   bit            m_pop = 1'b0;
   int            m_state;            // 0 idle, 1 run, 2 halt
   bit            h_vld[NC];
   rec_t          h_rec[NC];
   bit            mk_vld;
   logic [TW-1:0] mk_tag, m_tag;
   int            m_ts, m_rr;
   logic [NC:0]   m_drop;

   always @(posedge clk) begin : model
      bit active, pop, full, wr_ok, seg, mark_wr, fire;
      int g, c;
      bit [NC-1:0] freed;
      rec_t junk;
      if (rst) begin
         exp_q.delete();
         m_state = 0; mk_vld = 1'b0; mk_tag = '0; m_tag = '0; m_ts = 0; m_rr = 0; m_drop = '0;
         for (int i = 0; i < NC; i++) h_vld[i] = 1'b0;
      end else begin
         active = (m_state != 0);
         pop    = m_pop;
         full   = ((exp_q.size() + int'(pop)) == DEP);
         wr_ok  = !full || pop || cfg_mode;
         freed  = '0; mark_wr = 1'b0; g = -1;
         if (wr_ok && mk_vld) begin
            exp_q.push_back(mk_rec(1, 0, mk_tag, 0, '0, '0));
            mark_wr = 1'b1;
         end else if (wr_ok) begin
            for (int k = 0; k < NC; k++) begin
               c = (m_rr + k) % NC;
               if (g < 0 && h_vld[c]) g = c;
            end
            if (g >= 0) begin
               exp_q.push_back(h_rec[g]);
               freed[g] = 1'b1;
               m_rr = (g + 1) % NC;
            end
         end
         if ((mark_wr || g >= 0) && full && !pop) junk = exp_q.pop_front();
         seg = seg_start && active;
         for (int i = 0; i < NC; i++) begin
            fire = mon_val[i] && mon_rdy[i] && cfg_ch_mask[i] && active;
            if (fire && h_vld[i] && !freed[i]) m_drop[i] = 1'b1;
            else if (fire) begin
               h_vld[i] = 1'b1;
               h_rec[i] = mk_rec(0, i, seg ? seg_tag : m_tag, seg ? 0 : m_ts,
                                 mon_addr[i*AW +: AW], mon_data[i*DW +: DW]);
            end else if (freed[i]) h_vld[i] = 1'b0;
         end
         if (seg) begin
            if (mk_vld && !mark_wr) m_drop[NC] = 1'b1;
            mk_vld = 1'b1; mk_tag = seg_tag; m_tag = seg_tag; m_ts = 0;
         end else begin
            if (mark_wr) mk_vld = 1'b0;
            if (active) m_ts = (m_ts + 1) % (1 << SW);
         end
         case (m_state)
            0: if (cfg_en) begin m_state = 1; m_drop = '0; end
            1: if (!cfg_en) m_state = 0; else if (full && !cfg_mode && !pop) m_state = 2;
            2: if (!cfg_en) m_state = 0; else if (pop) m_state = 1;
            default: m_state = 0;
         endcase
      end
      m_pop = 1'b0;
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      int n;
      rec_t junk;
      if (mon_on) begin
         n = exp_q.size();
         chk("rd_val", 256'(rd_val), 256'(n != 0));
         chk("trc_cnt", 256'(trc_cnt), 256'(n));
         chk("trc_full", 256'(trc_full), 256'(n == DEP));
         chk("trc_drop", 256'(trc_drop), 256'(m_drop));
         if (n != 0) begin
            chk("rd_data", 256'(rd_data), 256'(exp_q[0]));
            if (rd_rdy) begin
               junk  = exp_q.pop_front();
               m_pop = 1'b1;
            end
         end else begin
            chk("rd_data_empty", 256'(rd_data), 256'(0));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic rnd_beats();
      for (int i = 0; i < NC; i++) begin
         mon_data[i*DW +: DW] = rnd_data();
         mon_addr[i*AW +: AW] = AW'($urandom);
      end
   endtask

   task automatic idle_toggle();
      cfg_en = 1'b0; cyc(1);
      cfg_en = 1'b1; cyc(1);
   endtask

   task automatic ch0_stream(input int n, input int base);
      for (int k = 0; k < n; k++) begin
         mon_val = 4'b0001; mon_rdy = 4'b0001;
         mon_data[DW-1:0] = DW'(base + k);
         mon_addr[AW-1:0] = AW'(k);
         cyc(1);
      end
      mon_val = '0;
   endtask

   initial begin
      rst = 1'b1; cfg_en = 1'b0; cfg_mode = 1'b0; cfg_ch_mask = 4'hF; seg_start = 1'b0;
      seg_tag = '0; mon_val = '0; mon_rdy = '0; mon_data = '0; mon_addr = '0; rd_rdy = 1'b1;
      cyc(1);
      mon_on = 1'b1;
      cyc(1);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_rd_data", 256'(rd_data), 256'(0));
      chk("reset_cnt", 256'(trc_cnt), 256'(0));

      // T1: single beat after a segment marker
      cfg_en = 1'b1; cyc(1);
      seg_start = 1'b1; seg_tag = 18'h01234; cyc(1);
      seg_start = 1'b0; cyc(2);
      mon_val = 4'b0010; mon_rdy = 4'b0010;
      mon_addr[AW +: AW] = 16'h0012; mon_data[DW +: DW] = 128'd5;
      cyc(1);
      mon_val = '0;
      @(negedge clk);
      chk("t1_not_yet", 256'(rd_val), 256'(0));
      cyc(1);
      @(negedge clk);
      chk("t1_val_at_fire_plus2", 256'(rd_val), 256'(1));
      chk("t1_beat", 256'(rd_data), 256'(mk_rec(0, 1, 18'h01234, 2, 16'h0012, 128'd5)));
      cyc(3);

      // T2: simultaneous bursts drained in round-robin order
      for (int b = 0; b < 2; b++) begin
         rnd_beats(); mon_val = 4'hF; mon_rdy = 4'hF; cyc(1);
         mon_val = '0; cyc(7);
      end

      // T3: stop-when-full
      idle_toggle();
      cfg_mode = 1'b0; rd_rdy = 1'b0;
      ch0_stream(DEP + 3, 0);
      cyc(3);
      @(negedge clk);
      chk("t3_cnt", 256'(trc_cnt), 256'(64));
      chk("t3_full", 256'(trc_full), 256'(1));
      chk("t3_drop0", 256'(trc_drop[0]), 256'(1));
      rd_rdy = 1'b1; cyc(1);
      rd_rdy = 1'b0; cyc(1);
      @(negedge clk);
      chk("t3_refill", 256'(trc_cnt), 256'(64));
      rd_rdy = 1'b1; cyc(DEP + 6);

      // T4: wrap mode overwrites oldest
      idle_toggle();
      cfg_mode = 1'b1; rd_rdy = 1'b0;
      ch0_stream(DEP + 5, 0);
      cyc(3);
      @(negedge clk);
      chk("t4_cnt", 256'(trc_cnt), 256'(64));
      chk("t4_head", 256'(rd_data[DW-1:0]), 256'(5));
      chk("t4_nodrop", 256'(trc_drop), 256'(0));
      rd_rdy = 1'b1; cyc(DEP + 6);

      // T5: two markers while the FIFO is blocked
      idle_toggle();
      cfg_mode = 1'b0; rd_rdy = 1'b0;
      for (int k = 0; k < DEP + 10; k++) begin
         rnd_beats(); mon_val = 4'b0100; mon_rdy = 4'b0100;
         seg_start = (k == DEP + 5) || (k == DEP + 6);
         seg_tag   = (k == DEP + 5) ? 18'h2AAAA : 18'h15555;
         cyc(1);
      end
      mon_val = '0; seg_start = 1'b0; cyc(1);
      @(negedge clk);
      chk("t5_mark_drop", 256'(trc_drop[NC]), 256'(1));
      rd_rdy = 1'b1; cyc(DEP + 10);

      // T6: reset mid-burst, then masked channels capture nothing
      cfg_mode = 1'b1;
      for (int k = 0; k < 30; k++) begin
         rnd_beats(); mon_val = NC'($urandom); mon_rdy = NC'($urandom); rd_rdy = 1'($urandom);
         cyc(1);
      end
      rst = 1'b1; cyc(1);
      rst = 1'b0; cfg_ch_mask = '0; mon_val = '1; mon_rdy = '1; cfg_en = 1'b1; rd_rdy = 1'b1;
      cyc(20);
      @(negedge clk);
      chk("t6_cnt", 256'(trc_cnt), 256'(0));
      chk("t6_val", 256'(rd_val), 256'(0));
      chk("t6_data", 256'(rd_data), 256'(0));
      chk("t6_drop", 256'(trc_drop), 256'(0));
      chk("t6_full", 256'(trc_full), 256'(0));

      // Random traffic
      begin
         int rdy_pct;
         rdy_pct = 50;
         for (int c = 0; c < 3000; c++) begin
            if (c % 256 == 0) cfg_mode = 1'($urandom);
            if (c % 50 == 0) cfg_ch_mask = NC'($urandom);
            if (c % 300 == 0) rdy_pct = ($urandom_range(0, 2) == 0) ? 5 : (($urandom_range(0, 1) == 0) ? 50 : 95);
            cfg_en    = ($urandom_range(0, 149) != 0);
            seg_start = ($urandom_range(0, 25) == 0);
            seg_tag   = TW'($urandom);
            mon_val   = NC'($urandom);
            mon_rdy   = NC'($urandom);
            rd_rdy    = ($urandom_range(0, 99) < rdy_pct);
            rnd_beats();
            cyc(1);
         end
      end
      mon_val = '0; seg_start = 1'b0; rd_rdy = 1'b1; cfg_en = 1'b1;
      cyc(DEP + 10);
      @(negedge clk);
      chk("final_empty", 256'(trc_cnt), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
